// File: rtl/bcd_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner_if
// Purpose  : Bus between the BCD counter bank and the multiplexed display.
// Revision : 1.0
// ============================================================================
interface bcd_display_scanner_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd_in;
   logic                load;
   logic                blank_lz;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;
   logic                err;

   modport master (
      output bcd_in, load, blank_lz,
      input  seg, an, err
   );

   modport slave (
      input  bcd_in, load, blank_lz,
      output seg, an, err
   );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Holds a packed BCD word and scans it onto a shared 7-segment bus.
// Revision : 1.0
// ============================================================================
module bcd_display_scanner #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   bcd_display_scanner_if.slave   bus
);

   localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [IW-1:0]     c_idx_max = IW'(DIGITS - 1);
   localparam logic [DW-1:0]     c_div_max = DW'(SCAN_DIV - 1);
   localparam logic [DIGITS-1:0] c_an_one  = DIGITS'(1);

   logic [4*DIGITS-1:0] r_held;
   logic [DW-1:0]       r_div;
   logic [IW-1:0]       r_idx;
   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_an;
   logic                r_err;

   logic [3:0]          w_nib;
   logic [DIGITS-1:0]   w_zero_from;
   logic                w_run;
   logic                w_blank;
   logic [6:0]          w_seg;
   logic                w_bad;
   logic                w_adv;

   assign w_adv = (r_div == c_div_max);
   assign w_nib = r_held[{r_idx, 2'b00} +: 4];

   // w_zero_from[i]: nibble i and every nibble above it are zero
   always_comb begin
      w_run       = 1'b1;
      w_zero_from = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_run          = w_run & (r_held[4*i +: 4] == 4'd0);
         w_zero_from[i] = w_run;
      end
   end

   assign w_blank = bus.blank_lz && (r_idx != '0) && w_zero_from[r_idx];

   always_comb begin
      w_seg = 7'h40;
      case (w_nib)
         4'd0:    w_seg = 7'h3F;
         4'd1:    w_seg = 7'h06;
         4'd2:    w_seg = 7'h5B;
         4'd3:    w_seg = 7'h4F;
         4'd4:    w_seg = 7'h66;
         4'd5:    w_seg = 7'h6D;
         4'd6:    w_seg = 7'h7D;
         4'd7:    w_seg = 7'h07;
         4'd8:    w_seg = 7'h7F;
         4'd9:    w_seg = 7'h6F;
         default: w_seg = 7'h40;
      endcase
      if (w_blank) begin
         w_seg = 7'h00;
      end
   end

   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         w_bad = w_bad | (bus.bcd_in[4*i +: 4] > 4'd9);
      end
   end

   // seg and an come from the same register stage so they always switch together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_held <= '0;
         r_div  <= '0;
         r_idx  <= '0;
         r_seg  <= '0;
         r_an   <= '0;
         r_err  <= 1'b0;
      end else begin
         if (bus.load) begin
            r_held <= bus.bcd_in;
            r_err  <= w_bad;
         end
         if (w_adv) begin
            r_div <= '0;
            r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         r_seg <= w_seg;
         r_an  <= c_an_one << r_idx;
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;
   assign bus.err = r_err;

endmodule
`default_nettype wire
